// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM 5-stage pipeline control blocks.
//   mem_state_e : state encoding of the MEM-stage SRAM access sequencer
//   REG_W       : architectural register-number width
//   PC_REG      : register number that aliases the program counter
package arm_pipe_pkg;

    localparam int REG_W  = 4;
    localparam int PC_REG = 15;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage : arm_pipe_pkg

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detector between the ID stage and the EX/MEM stages.
// Ports:
//   forward_en            in  forwarding unit enabled (only load-use stalls remain)
//   id_valid              in  ID stage holds a real instruction
//   id_src1, id_src2      in  ID-stage source register numbers
//   id_two_src            in  id_src2 is actually read
//   exe_dest              in  EX-stage destination register
//   exe_wb_en             in  EX-stage instruction writes back
//   exe_mem_r_en          in  EX-stage instruction is a load
//   mem_dest              in  MEM-stage destination register
//   mem_wb_en             in  MEM-stage instruction writes back
//   haz                   out ID must stall one cycle
module hazard_detect
    import arm_pipe_pkg::*;
(
    input  logic             forward_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             haz
);

    // True when the ID instruction reads the given destination register.
    function automatic logic src_match(input logic [REG_W-1:0] dest,
                                       input logic             valid,
                                       input logic [REG_W-1:0] src1,
                                       input logic [REG_W-1:0] src2,
                                       input logic             two_src);
        return valid && ((src1 == dest) || (two_src && (src2 == dest)));
    endfunction

    logic exe_match;
    logic mem_match;

    assign exe_match = src_match(exe_dest, id_valid, id_src1, id_src2, id_two_src);
    assign mem_match = src_match(mem_dest, id_valid, id_src1, id_src2, id_two_src);

    always_comb begin
        haz = 1'b0;
        if (forward_en) begin
            // Forwarding covers every ALU result; only a load in EX cannot be
            // forwarded in time.
            haz = exe_match && exe_mem_r_en;
        end else begin
            haz = (exe_match && exe_wb_en) || (mem_match && mem_wb_en);
        end
    end

endmodule : hazard_detect

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage ARM pipeline.
// Sequences multi-cycle SRAM accesses from MEM, stalls ID on RAW hazards and
// converts taken branches into flushes.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   forward_en               forwarding unit enabled
//   id_src1/id_src2/id_two_src/id_valid   ID-stage operand info
//   exe_dest/exe_wb_en/exe_mem_r_en       EX-stage control
//   mem_dest/mem_wb_en/mem_access         MEM-stage control
//   branch_taken             taken branch resolved in EX
//   sram_ready               SRAM access completes this cycle
//   mem_req                  out SRAM request
//   freeze_front             out freeze PC and IF/ID
//   freeze_all               out freeze ID/EX, EX/MEM, MEM/WB
//   flush_if, flush_id       out flush IF/ID, ID/EX
//   mem_err                  out sticky SRAM timeout flag (registered)
//   stall_cnt                out saturating count of freeze_front cycles (registered)
module pipe_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_valid,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_access,
    input  logic             branch_taken,
    input  logic             sram_ready,
    output logic             mem_req,
    output logic             freeze_front,
    output logic             freeze_all,
    output logic             flush_if,
    output logic             flush_id,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(TIMEOUT);

    mem_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              haz;

    hazard_detect u_hazard_detect (
        .forward_en   (forward_en),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .haz          (haz)
    );

    // Memory access sequencer. sram_ready is deliberately ignored in IDLE so
    // a stale ready from the previous access cannot complete a new one.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        freeze_all = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_access) begin
                    mem_req    = 1'b1;
                    freeze_all = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                mem_req    = 1'b1;
                freeze_all = ~sram_ready;
                if (sram_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Priority: memory freeze > branch flush > hazard bubble. While frozen
    // the branch stays held in EX, so the flush simply happens later.
    always_comb begin
        freeze_front = 1'b0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        if (freeze_all) begin
            freeze_front = 1'b1;
        end else if (branch_taken) begin
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (haz) begin
            freeze_front = 1'b1;
            flush_id     = 1'b1;
        end
    end

    // WAIT-cycle counter saturates at TIMEOUT; the FSM keeps waiting after
    // a timeout, only the sticky flag reports it.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == WAIT) begin
            wait_cnt_d = (wait_cnt_q == TIMEOUT_V) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        mem_err_d = mem_err_q | (wait_cnt_d == TIMEOUT_V);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze_front && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (TIMEOUT = 8).
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        forward_en;
    logic [3:0]  id_src1, id_src2;
    logic        id_two_src, id_valid;
    logic [3:0]  exe_dest;
    logic        exe_wb_en, exe_mem_r_en;
    logic [3:0]  mem_dest;
    logic        mem_wb_en, mem_access, branch_taken, sram_ready;
    logic        mem_req, freeze_front, freeze_all, flush_if, flush_id, mem_err;
    logic [15:0] stall_cnt;

    logic [4:0]  outs;
    logic [15:0] exp_stall;
    int          checks;
    int          errors;

    assign outs = {mem_req, freeze_front, freeze_all, flush_if, flush_id};

    pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .forward_en   (forward_en),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_valid     (id_valid),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_access   (mem_access),
        .branch_taken (branch_taken),
        .sram_ready   (sram_ready),
        .mem_req      (mem_req),
        .freeze_front (freeze_front),
        .freeze_all   (freeze_all),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        forward_en   = 1'b0;
        id_src1      = 4'd0;
        id_src2      = 4'd0;
        id_two_src   = 1'b0;
        id_valid     = 1'b0;
        exe_dest     = 4'd0;
        exe_wb_en    = 1'b0;
        exe_mem_r_en = 1'b0;
        mem_dest     = 4'd0;
        mem_wb_en    = 1'b0;
        mem_access   = 1'b0;
        branch_taken = 1'b0;
        sram_ready   = 1'b0;
    endtask

    // outs = {mem_req, freeze_front, freeze_all, flush_if, flush_id}

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, 5'b00000); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        checks++;
        if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
        tick();
        rst = 1'b0;
        exp_stall = 16'd0;
        $display("reset: outs=%b stall_cnt=%0d mem_err=%b", outs, stall_cnt, mem_err);
    endtask

    task automatic test_hazard_fwd_off();
        clear_inputs();
        id_valid = 1'b1; id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01001) begin errors++; $display("FAIL haz_exe_nofwd: got %b want %b", outs, 5'b01001); end
        tick(); exp_stall = exp_stall + 16'd1;
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL haz_exe_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        $display("haz exe fwd off: outs=%b stall_cnt=%0d", outs, stall_cnt);

        exe_wb_en = 1'b0; exe_dest = 4'd5; mem_dest = 4'd3; mem_wb_en = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01001) begin errors++; $display("FAIL haz_mem_nofwd: got %b want %b", outs, 5'b01001); end
        tick(); exp_stall = exp_stall + 16'd1;
        $display("haz mem fwd off: outs=%b stall_cnt=%0d", outs, stall_cnt);

        mem_wb_en = 1'b0; id_src1 = 4'd1; id_src2 = 4'd5; id_two_src = 1'b0; exe_wb_en = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL haz_src2_unused: got %b want %b", outs, 5'b00000); end
        tick();
        id_two_src = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01001) begin errors++; $display("FAIL haz_src2_used: got %b want %b", outs, 5'b01001); end
        tick(); exp_stall = exp_stall + 16'd1;
        id_valid = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL haz_id_invalid: got %b want %b", outs, 5'b00000); end
        tick();
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL haz_total_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        $display("haz src2/valid: outs=%b stall_cnt=%0d", outs, stall_cnt);
    endtask

    task automatic test_load_use();
        clear_inputs();
        forward_en = 1'b1; id_valid = 1'b1; id_src1 = 4'd3;
        exe_dest = 4'd3; exe_wb_en = 1'b1; mem_dest = 4'd3; mem_wb_en = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL fwd_no_stall: got %b want %b", outs, 5'b00000); end
        tick();
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL fwd_no_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        exe_mem_r_en = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b01001) begin errors++; $display("FAIL load_use_stall: got %b want %b", outs, 5'b01001); end
        tick(); exp_stall = exp_stall + 16'd1;
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL load_use_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        exe_mem_r_en = 1'b0; exe_wb_en = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL load_use_release: got %b want %b", outs, 5'b00000); end
        tick();
        $display("load-use: outs=%b stall_cnt=%0d", outs, stall_cnt);
    endtask

    task automatic test_sram_wait();
        clear_inputs();
        mem_access = 1'b1; sram_ready = 1'b1;   // ready must be ignored in IDLE
        #1;
        checks++;
        if (outs !== 5'b11100) begin errors++; $display("FAIL sram_idle_req: got %b want %b", outs, 5'b11100); end
        tick(); exp_stall = exp_stall + 16'd1;
        sram_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            checks++;
            if (outs !== 5'b11100) begin errors++; $display("FAIL sram_wait_%0d: got %b want %b", i, outs, 5'b11100); end
            tick(); exp_stall = exp_stall + 16'd1;
        end
        sram_ready = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b10000) begin errors++; $display("FAIL sram_ready_cycle: got %b want %b", outs, 5'b10000); end
        tick();
        mem_access = 1'b0; sram_ready = 1'b0;
        #1;
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL sram_back_idle: got %b want %b", outs, 5'b00000); end
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL sram_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        tick();
        $display("sram wait: outs=%b stall_cnt=%0d", outs, stall_cnt);
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        mem_access = 1'b1;
        tick(); exp_stall = exp_stall + 16'd1;  // IDLE -> WAIT
        sram_ready = 1'b1;
        tick();                                 // completes, back to IDLE
        #1;
        checks++;
        if (outs !== 5'b11100) begin errors++; $display("FAIL b2b_reenter_idle: got %b want %b", outs, 5'b11100); end
        tick(); exp_stall = exp_stall + 16'd1;  // IDLE -> WAIT again
        #1;
        checks++;
        if (outs !== 5'b10000) begin errors++; $display("FAIL b2b_second_ready: got %b want %b", outs, 5'b10000); end
        tick();
        mem_access = 1'b0; sram_ready = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL b2b_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        tick();
        $display("back-to-back: outs=%b stall_cnt=%0d", outs, stall_cnt);
    endtask

    task automatic test_branch();
        clear_inputs();
        // Branch and hazard together without a freeze: flush wins, no stall.
        branch_taken = 1'b1; id_valid = 1'b1; id_src1 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b00011) begin errors++; $display("FAIL branch_over_haz: got %b want %b", outs, 5'b00011); end
        tick();
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL branch_no_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        // Branch held during an SRAM freeze.
        mem_access = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b11100) begin errors++; $display("FAIL branch_frozen_idle: got %b want %b", outs, 5'b11100); end
        tick(); exp_stall = exp_stall + 16'd1;
        #1;
        checks++;
        if (outs !== 5'b11100) begin errors++; $display("FAIL branch_frozen_wait: got %b want %b", outs, 5'b11100); end
        tick(); exp_stall = exp_stall + 16'd1;
        sram_ready = 1'b1;
        #1;
        checks++;
        if (outs !== 5'b10011) begin errors++; $display("FAIL branch_after_ready: got %b want %b", outs, 5'b10011); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL branch_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        tick();
        $display("branch: outs=%b stall_cnt=%0d", outs, stall_cnt);
    endtask

    task automatic test_timeout();
        clear_inputs();
        checks++;
        if (mem_err !== 1'b0) begin errors++; $display("FAIL timeout_pre: got %b want 0", mem_err); end
        mem_access = 1'b1;
        tick(); exp_stall = exp_stall + 16'd1;  // now in WAIT
        mem_access = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick(); exp_stall = exp_stall + 16'd1;
        end
        checks++;
        if (mem_err !== 1'b0) begin errors++; $display("FAIL timeout_7_cycles: got %b want 0", mem_err); end
        tick(); exp_stall = exp_stall + 16'd1;
        checks++;
        if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_8_cycles: got %b want 1", mem_err); end
        tick(); exp_stall = exp_stall + 16'd1;
        tick(); exp_stall = exp_stall + 16'd1;
        checks++;
        if (outs !== 5'b11100) begin errors++; $display("FAIL timeout_still_waiting: got %b want %b", outs, 5'b11100); end
        sram_ready = 1'b1;
        tick();
        sram_ready = 1'b0;
        #1;
        checks++;
        if (mem_err !== 1'b1 || outs !== 5'b00000) begin errors++; $display("FAIL timeout_sticky: got err=%b outs=%b want err=1 outs=00000", mem_err, outs); end
        checks++;
        if (stall_cnt !== exp_stall) begin errors++; $display("FAIL timeout_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        tick();
        $display("timeout: mem_err=%b stall_cnt=%0d", mem_err, stall_cnt);
    endtask

    task automatic test_async_reset();
        clear_inputs();
        mem_access = 1'b1;
        tick();                 // IDLE -> WAIT
        mem_access = 1'b0;
        tick();                 // still WAIT
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL areset_pre_req: got %b want 1", mem_req); end
        #2;
        rst = 1'b1;             // between edges
        #1;
        checks++;
        if (outs !== 5'b00000) begin errors++; $display("FAIL areset_outs: got %b want %b", outs, 5'b00000); end
        checks++;
        if (stall_cnt !== 16'd0 || mem_err !== 1'b0) begin errors++; $display("FAIL areset_regs: got cnt=%0d err=%b want cnt=0 err=0", stall_cnt, mem_err); end
        #1;
        rst = 1'b0;
        exp_stall = 16'd0;
        tick();
        checks++;
        if (outs !== 5'b00000 || stall_cnt !== 16'd0) begin errors++; $display("FAIL areset_after: got outs=%b cnt=%0d want 00000/0", outs, stall_cnt); end
        $display("async reset: outs=%b stall_cnt=%0d mem_err=%b", outs, stall_cnt, mem_err);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_stall = 16'd0;
        test_reset();
        test_hazard_fwd_off();
        test_load_use();
        test_sram_wait();
        test_back_to_back();
        test_branch();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
